cluster_clock_gate_ctrl: RTL

Controller that drives the enable input of the cluster clock-gating cell. It runs on the ungated clock and watches cluster busy and wake-event inputs. After a programmable number of idle cycles it deasserts the gate enable. On any wake condition it re-enables the clock and holds off a ready indication for a fixed number of settling cycles.

---
 rtl/cluster_cg_pkg.sv | 14 +
 rtl/cg_sat_counter.sv | 24 ++
 rtl/cluster_clock_gate_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/cluster_cg_pkg.sv
// rtl/cluster_cg_pkg.sv - shared state encoding and default sizing for the cluster clock-gate controller
package cluster_cg_pkg;

  localparam int CG_CNT_WIDTH   = 8;
  localparam int CG_WAKE_CYCLES = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDLE  = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } cg_state_e;

endpackage

// File: rtl/cg_sat_counter.sv
// rtl/cg_sat_counter.sv - saturating event counter with synchronous clear (clear beats increment)
module cg_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/cluster_clock_gate_ctrl.sv
// rtl/cluster_clock_gate_ctrl.sv - idle-driven clock-gate enable FSM; CLK_GATE_STATS_EN adds a gated-cycle counter
module cluster_clock_gate_ctrl
  import cluster_cg_pkg::*;
#(
  parameter int CNT_WIDTH   = CG_CNT_WIDTH,
  parameter int WAKE_CYCLES = CG_WAKE_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [CNT_WIDTH-1:0] idle_thresh_i,
  input  logic                 busy_i,
  input  logic                 wake_i,
  output logic                 clk_en_o,
  output logic                 clk_gated_o,
  output logic                 ready_o,
  input  logic                 stat_clr_i,
  output logic [31:0]          gated_cycles_o
);

  localparam int WCW = $clog2(WAKE_CYCLES + 1);
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES - 1);

  cg_state_e            r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [WCW-1:0]       r_wake_cnt, w_wake_cnt_nxt;
  logic                 r_clk_en, r_gated, r_ready;
  logic                 w_idle;

  assign w_idle = enable_i & ~busy_i & ~wake_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_wake_cnt_nxt = r_wake_cnt;
    case (r_state)
      RUN: begin
        if (w_idle) begin
          w_state_nxt    = IDLE;
          w_idle_cnt_nxt = '0;
        end
      end
      IDLE: begin
        // Activity wins over the threshold so a late wake never closes the gate.
        if (!w_idle) begin
          w_state_nxt    = RUN;
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt >= idle_thresh_i) begin
          w_state_nxt = GATED;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
      end
      GATED: begin
        if (busy_i || wake_i || !enable_i) begin
          w_state_nxt    = WAKE;
          w_wake_cnt_nxt = '0;
        end
      end
      WAKE: begin
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_wake_cnt_nxt = r_wake_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Outputs are flopped from the next state so the gating cell sees a glitch-free enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_clk_en   <= 1'b1;
      r_gated    <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
      r_clk_en   <= (w_state_nxt != GATED);
      r_gated    <= (w_state_nxt == GATED);
      r_ready    <= (w_state_nxt == RUN) || (w_state_nxt == IDLE);
    end
  end

  assign clk_en_o    = r_clk_en;
  assign clk_gated_o = r_gated;
  assign ready_o     = r_ready;

`ifdef CLK_GATE_STATS_EN
  cg_sat_counter #(.WIDTH(32)) u_stats (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (stat_clr_i),
    .inc_i (r_state == GATED),
    .cnt_o (gated_cycles_o)
  );
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = stat_clr_i;
  assign gated_cycles_o    = '0;
`endif

endmodule
